// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-port arbiter for the shared on-chip memory
// One transaction per grant, a forced idle cycle between grants, and a watchdog on s_ready.
module mem_arbiter #(
   parameter int          TIMEOUT   = 16,
   parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_valid,
   input  logic        m0_instr,
   input  logic [3:0]  m0_wstrb,
   input  logic [31:0] m0_wdata,
   input  logic [31:0] m0_addr,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic        m1_instr,
   input  logic [3:0]  m1_wstrb,
   input  logic [31:0] m1_wdata,
   input  logic [31:0] m1_addr,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   output logic        s_instr,
   output logic [3:0]  s_wstrb,
   output logic [31:0] s_wdata,
   output logic [31:0] s_addr,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   output logic [1:0]  grant,
   input  logic        err_clr,
   output logic        bus_err
);

   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      BUSY0 = 2'b01,
      BUSY1 = 2'b10
   } state_t;

   state_t        state;
   logic          last;
   logic [CW-1:0] cnt;
   logic          cur_valid;
   logic          tmo;
   logic          done;
   logic [31:0]   rsp_data;

   // The state encoding is the one-hot grant itself, so grant is a registered output.
   assign grant = state;

   assign cur_valid = ((state == BUSY0) && m0_valid) || ((state == BUSY1) && m1_valid);
   assign tmo       = cur_valid && !s_ready && (cnt == CW'(TIMEOUT - 1));
   assign done      = cur_valid && (s_ready || tmo);
   assign rsp_data  = s_ready ? s_rdata : ERR_RDATA;

   assign s_valid  = cur_valid;
   assign m0_ready = (state == BUSY0) && done;
   assign m1_ready = (state == BUSY1) && done;
   assign m0_rdata = m0_ready ? rsp_data : 32'h0;
   assign m1_rdata = m1_ready ? rsp_data : 32'h0;

   always_comb begin
      s_instr = 1'b0;
      s_wstrb = 4'h0;
      s_wdata = 32'h0;
      s_addr  = 32'h0;
      case (state)
         BUSY0: begin
            s_instr = m0_instr;
            s_wstrb = m0_wstrb;
            s_wdata = m0_wdata;
            s_addr  = m0_addr;
         end
         BUSY1: begin
            s_instr = m1_instr;
            s_wstrb = m1_wstrb;
            s_wdata = m1_wdata;
            s_addr  = m1_addr;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         last    <= 1'b1;
         cnt     <= '0;
         bus_err <= 1'b0;
      end else begin
         if (tmo)
            bus_err <= 1'b1;
         else if (err_clr)
            bus_err <= 1'b0;

         case (state)
            IDLE: begin
               cnt <= '0;
               // On a tie the port that did not win last time goes first.
               if (m0_valid && (!m1_valid || last)) begin
                  state <= BUSY0;
                  last  <= 1'b0;
               end else if (m1_valid) begin
                  state <= BUSY1;
                  last  <= 1'b1;
               end
            end
            default: begin
               if (!cur_valid || done) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Registered-ready memory model with programmable latency; scoreboard of expected responses.
module tb_mem_arbiter;

   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        resetn;
   logic        m0_valid, m0_instr, m1_valid, m1_instr;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic [31:0] m0_wdata, m0_addr, m1_wdata, m1_addr;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_valid, s_instr, s_ready;
   logic [3:0]  s_wstrb;
   logic [31:0] s_wdata, s_addr, s_rdata;
   logic [1:0]  grant;
   logic        err_clr, bus_err;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.TIMEOUT(16), .ERR_RDATA(ERR)) dut (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata),
      .m0_addr(m0_addr), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata),
      .m1_addr(m1_addr), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_instr(s_instr), .s_wstrb(s_wstrb), .s_wdata(s_wdata),
      .s_addr(s_addr), .s_ready(s_ready), .s_rdata(s_rdata),
      .grant(grant), .err_clr(err_clr), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   // Memory model: ready is registered and rises lat cycles after s_valid (lat = 0 never answers).
   logic [31:0] mem [0:63];
   int lat = 1;
   int mcnt = 0;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s_ready <= 1'b0;
         s_rdata <= 32'h0;
         mcnt    <= 0;
      end else if (s_valid && !s_ready) begin
         mcnt    <= mcnt + 1;
         s_ready <= (mcnt + 1 == lat);
         if (mcnt + 1 == lat) begin
            s_rdata <= mem[s_addr[7:2]];
            for (int b = 0; b < 4; b++)
               if (s_wstrb[b]) mem[s_addr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
         end
      end else begin
         mcnt    <= 0;
         s_ready <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        port;
      logic        chk;
      logic [31:0] rdata;
   } sb_t;
   sb_t sb[$];
   sb_t e;

   always @(negedge clk) begin
      if (resetn) begin
         if (!m0_ready) check("m0_rdata_idle", m0_rdata, 32'h0);
         if (!m1_ready) check("m1_rdata_idle", m1_rdata, 32'h0);
         if (m0_ready || m1_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected_ready: got ready %b%b expected none", m1_ready, m0_ready);
            end else begin
               e = sb.pop_front();
               check("ready_port", {30'h0, m1_ready, m0_ready}, e.port ? 32'h2 : 32'h1);
               if (e.chk) check("rdata", m1_ready ? m1_rdata : m0_rdata, e.rdata);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input logic port, output int n);
      n = 1;
      while (!(port ? m1_ready : m0_ready) && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      m0_valid = 1'b0;
      m1_valid = 1'b0;
      err_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   // Entered at posedge+1 with the arbiter idle; ends at the negedge of the idle cycle.
   task automatic run_txn(input logic port, input logic instr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input logic [31:0] addr,
                          input logic chk, input logic [31:0] exp, input int exp_n);
      int n;
      sb.push_back('{port, chk, exp});
      if (!port) begin
         m0_valid = 1'b1; m0_instr = instr; m0_wstrb = wstrb; m0_wdata = wdata; m0_addr = addr;
      end else begin
         m1_valid = 1'b1; m1_instr = instr; m1_wstrb = wstrb; m1_wdata = wdata; m1_addr = addr;
      end
      @(negedge clk);
      check("grant_req_cycle", {30'h0, grant}, 32'h0);
      @(negedge clk);
      check("grant_busy", {30'h0, grant}, port ? 32'h2 : 32'h1);
      check("s_valid_busy", {31'h0, s_valid}, 32'h1);
      check("s_addr", s_addr, addr);
      check("s_wdata", s_wdata, wdata);
      check("s_wstrb", {28'h0, s_wstrb}, {28'h0, wstrb});
      check("s_instr", {31'h0, s_instr}, {31'h0, instr});
      check("other_ready", {31'h0, port ? m0_ready : m1_ready}, 32'h0);
      wait_ready(port, n);
      check("latency", n, exp_n);
      tick();
      if (!port) m0_valid = 1'b0; else m1_valid = 1'b0;
      @(negedge clk);
      check("grant_after", {30'h0, grant}, 32'h0);
      check("s_valid_after", {31'h0, s_valid}, 32'h0);
   endtask

   typedef struct {
      logic        port;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[6];

   logic [1:0] exp_gr [13];

   initial begin
      int n;
      vecs[0] = '{1'b0, 4'b0000, 32'h10, 32'h0,         32'h1234_5678};
      vecs[1] = '{1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, 32'h0};
      vecs[2] = '{1'b0, 4'b0000, 32'h20, 32'h0,         32'h11BB_11DD};
      vecs[3] = '{1'b1, 4'b0000, 32'h10, 32'h0,         32'h1234_5678};
      vecs[4] = '{1'b0, 4'b1111, 32'h24, 32'hCAFE_F00D, 32'h0};
      vecs[5] = '{1'b1, 4'b0000, 32'h24, 32'h0,         32'hCAFE_F00D};
      exp_gr = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[4] = 32'h1234_5678;
      mem[8] = 32'h1111_1111;
      {m0_instr, m0_wstrb, m0_wdata, m0_addr} = '0;
      {m1_instr, m1_wstrb, m1_wdata, m1_addr} = '0;
      do_reset();

      @(negedge clk);
      check("rst_grant", {30'h0, grant}, 32'h0);
      check("rst_s_valid", {31'h0, s_valid}, 32'h0);
      check("rst_ready", {30'h0, m1_ready, m0_ready}, 32'h0);
      check("rst_bus_err", {31'h0, bus_err}, 32'h0);
      tick();

      for (int i = 0; i < 6; i++) begin
         run_txn(vecs[i].port, (i % 2) == 0, vecs[i].wstrb, vecs[i].wdata, vecs[i].addr,
                 vecs[i].wstrb == 4'b0000, vecs[i].exp, 2);
         tick();
      end

      // Contention: both held valid for four transactions after reset.
      do_reset();
      m0_addr = 32'h10; m0_wstrb = 4'h0;
      m1_addr = 32'h24; m1_wstrb = 4'h0;
      for (int k = 0; k < 4; k++)
         sb.push_back('{k[0], 1'b1, k[0] ? 32'hCAFE_F00D : 32'h1234_5678});
      m0_valid = 1'b1;
      m1_valid = 1'b1;
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         check("rr_grant", {30'h0, grant}, {30'h0, exp_gr[k]});
         check("rr_s_valid", {31'h0, s_valid}, {31'h0, exp_gr[k] != 2'b00});
         tick();
         if (k == 11) begin
            m0_valid = 1'b0;
            m1_valid = 1'b0;
         end
      end

      // Timeout, sticky error, clear, then s_ready arriving exactly in the last cycle.
      lat = 0;
      run_txn(1'b0, 1'b0, 4'h0, 32'h0, 32'h10, 1'b1, ERR, 16);
      check("bus_err_set", {31'h0, bus_err}, 32'h1);
      repeat (3) tick();
      @(negedge clk);
      check("bus_err_held", {31'h0, bus_err}, 32'h1);
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      @(negedge clk);
      check("bus_err_clr", {31'h0, bus_err}, 32'h0);
      tick();
      lat = 15;
      run_txn(1'b0, 1'b0, 4'h0, 32'h0, 32'h10, 1'b1, 32'h1234_5678, 16);
      check("bus_err_late_ok", {31'h0, bus_err}, 32'h0);
      tick();

      // Abort: m0 drops valid mid-transaction while m1 waits.
      lat = 0;
      m0_valid = 1'b1; m0_addr = 32'h10;
      tick();
      m1_valid = 1'b1; m1_addr = 32'h10;
      @(negedge clk);
      check("abort_grant", {30'h0, grant}, 32'h1);
      tick();
      m0_valid = 1'b0;
      @(negedge clk);
      check("abort_no_ready", {30'h0, m1_ready, m0_ready}, 32'h0);
      check("abort_s_valid", {31'h0, s_valid}, 32'h0);
      tick();
      lat = 1;
      @(negedge clk);
      check("abort_idle", {30'h0, grant}, 32'h0);
      tick();
      sb.push_back('{1'b1, 1'b1, 32'h1234_5678});
      @(negedge clk);
      check("abort_next_grant", {30'h0, grant}, 32'h2);
      wait_ready(1'b1, n);
      check("abort_m1_latency", n, 2);
      tick();
      m1_valid = 1'b0;
      tick();

      // Asynchronous reset in the middle of BUSY1.
      lat = 0;
      m1_valid = 1'b1;
      tick();
      @(negedge clk);
      check("pre_rst_grant", {30'h0, grant}, 32'h2);
      #2;
      resetn = 1'b0;
      #1;
      check("async_grant", {30'h0, grant}, 32'h0);
      check("async_s_valid", {31'h0, s_valid}, 32'h0);
      check("async_ready", {30'h0, m1_ready, m0_ready}, 32'h0);
      m1_valid = 1'b0;
      tick();
      resetn = 1'b1;
      lat = 1;
      sb.push_back('{1'b0, 1'b1, 32'h1234_5678});
      m0_valid = 1'b1; m0_addr = 32'h10;
      m1_valid = 1'b1;
      tick();
      @(negedge clk);
      check("post_rst_tie", {30'h0, grant}, 32'h1);
      tick();
      m1_valid = 1'b0;
      wait_ready(1'b0, n);
      check("post_rst_done", {31'h0, m0_ready}, 32'h1);
      tick();
      m0_valid = 1'b0;
      repeat (2) tick();

      check("sb_drained", sb.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before %0t", $time);
      $fatal(1);
   end

endmodule
